// File: rtl/branch_pc_if.sv
// Handshake bundle between the decode stage and branch_pc_unit.
// The decode stage uses the master modport; branch_pc_unit uses the slave modport.
interface branch_pc_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic              en;
    logic              instr_valid;
    logic [2:0]        op;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic [15:0]       imm;
    logic [25:0]       jidx;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic              taken;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output en, instr_valid, op, rs_val, rt_val, imm, jidx,
        input  pc, pc_plus4, taken, taken_cnt
    );

    modport slave (
        input  en, instr_valid, op, rs_val, rt_val, imm, jidx,
        output pc, pc_plus4, taken, taken_cnt
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Architectural PC register with BEQ/BNE/BLEZ/BGTZ/J resolution and a saturating redirect counter.
// Define BRANCH_DELAY_SLOT_EN to defer every redirect by one delay-slot instruction.
module branch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    branch_pc_if.slave  bus
);
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_BLEZ = 3'd3;
    localparam logic [2:0] OP_BGTZ = 3'd4;
    localparam logic [2:0] OP_J    = 3'd5;

`ifdef BRANCH_DELAY_SLOT_EN
    typedef enum logic {NORMAL, SLOT} state_t;
    logic [XLEN-1:0] pend_pc_reg;
`else
    typedef enum logic {NORMAL} state_t;
`endif

    state_t            state_reg;
    logic [XLEN-1:0]   pc_reg;
    logic              taken_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   br_target;
    logic [XLEN-1:0]   j_target;
    logic [XLEN-1:0]   target;
    logic              cond;
    logic              redirect_req;
    logic [CNT_W-1:0]  cnt_next;

    assign pc_plus4  = pc_reg + XLEN'(4);
    assign imm_ext   = {{(XLEN-18){bus.imm[15]}}, bus.imm, 2'b00};
    assign br_target = pc_plus4 + imm_ext;
    assign j_target  = {pc_plus4[XLEN-1:28], bus.jidx, 2'b00};
    assign target    = (bus.op == OP_J) ? j_target : br_target;

    always_comb begin
        cond = 1'b0;
        case (bus.op)
            OP_BEQ:  cond = (bus.rs_val == bus.rt_val);
            OP_BNE:  cond = (bus.rs_val != bus.rt_val);
            OP_BLEZ: cond = ($signed(bus.rs_val) <= $signed(XLEN'(0)));
            OP_BGTZ: cond = ($signed(bus.rs_val) >  $signed(XLEN'(0)));
            OP_J:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Only a NORMAL-state instruction may start a redirect.
    assign redirect_req = bus.instr_valid && cond && (state_reg == NORMAL);
    assign cnt_next     = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            taken_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= NORMAL;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_pc_reg <= '0;
`endif
        end else if (!bus.en) begin
            taken_reg <= 1'b0;
        end else begin
            taken_reg <= 1'b0;
            pc_reg    <= pc_plus4;
`ifdef BRANCH_DELAY_SLOT_EN
            case (state_reg)
                NORMAL: begin
                    if (redirect_req) begin
                        pend_pc_reg <= target;
                        state_reg   <= SLOT;
                    end
                end
                SLOT: begin
                    // Whatever sits in the delay slot is executed as a plain instruction.
                    pc_reg    <= pend_pc_reg;
                    taken_reg <= 1'b1;
                    cnt_reg   <= cnt_next;
                    state_reg <= NORMAL;
                end
                default: state_reg <= NORMAL;
            endcase
`else
            state_reg <= NORMAL;
            if (redirect_req) begin
                pc_reg    <= target;
                taken_reg <= 1'b1;
                cnt_reg   <= cnt_next;
            end
`endif
        end
    end

    assign bus.pc        = pc_reg;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.taken     = taken_reg;
    assign bus.taken_cnt = cnt_reg;
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed table-driven bench for branch_pc_unit: two instances (wide and 2-bit counters).
// Expectations follow BRANCH_DELAY_SLOT_EN when it is defined.
module tb_branch_pc_unit;
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_BLEZ = 3'd3;
    localparam logic [2:0] OP_BGTZ = 3'd4;
    localparam logic [2:0] OP_J    = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_pc_if #(.XLEN(32), .CNT_W(16)) bus_a ();
    branch_pc_if #(.XLEN(32), .CNT_W(2))  bus_b ();

    branch_pc_unit #(.XLEN(32), .RESET_PC(32'h0040_0000), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    branch_pc_unit #(.XLEN(32), .RESET_PC(32'h9000_0010), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic        sel;
        logic        en;
        logic        iv;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] exp_pc;
        logic        exp_taken;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic sel, input logic en, input logic iv, input logic [2:0] op,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                       input logic [25:0] jidx, input logic [31:0] exp_pc,
                       input logic exp_taken, input logic [15:0] exp_cnt);
        vec_t v;
        v.sel = sel; v.en = en; v.iv = iv; v.op = op; v.rs = rs; v.rt = rt;
        v.imm = imm; v.jidx = jidx; v.exp_pc = exp_pc; v.exp_taken = exp_taken;
        v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic en, input logic iv, input logic [2:0] op,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                         input logic [25:0] jidx);
        bus_a.en = 1'b0; bus_a.instr_valid = 1'b0; bus_a.op = OP_NONE;
        bus_a.rs_val = '0; bus_a.rt_val = '0; bus_a.imm = '0; bus_a.jidx = '0;
        bus_b.en = 1'b0; bus_b.instr_valid = 1'b0; bus_b.op = OP_NONE;
        bus_b.rs_val = '0; bus_b.rt_val = '0; bus_b.imm = '0; bus_b.jidx = '0;
        if (sel) begin
            bus_b.en = en; bus_b.instr_valid = iv; bus_b.op = op;
            bus_b.rs_val = rs; bus_b.rt_val = rt; bus_b.imm = imm; bus_b.jidx = jidx;
        end else begin
            bus_a.en = en; bus_a.instr_valid = iv; bus_a.op = op;
            bus_a.rs_val = rs; bus_a.rt_val = rt; bus_a.imm = imm; bus_a.jidx = jidx;
        end
    endtask

    task automatic check_a(input string tag, input logic [31:0] pc, input logic tk,
                           input logic [15:0] cnt);
        check({tag, " pc"}, bus_a.pc, pc);
        check({tag, " pc_plus4"}, bus_a.pc_plus4, pc + 32'd4);
        check({tag, " taken"}, {31'd0, bus_a.taken}, {31'd0, tk});
        check({tag, " taken_cnt"}, {16'd0, bus_a.taken_cnt}, {16'd0, cnt});
        $display("%s: pc=%08h taken=%b cnt=%0d", tag, bus_a.pc, bus_a.taken, bus_a.taken_cnt);
    endtask

    initial begin
        logic [31:0] act_pc;
        logic        act_tk;
        logic [15:0] act_cnt;

        // dut_a: sequential PC after reset (RESET_PC = 0x00400000)
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0, 32'h0040_0004,0,0);
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0, 32'h0040_0008,0,0);
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0, 32'h0040_000C,0,0);
`ifdef BRANCH_DELAY_SLOT_EN
        add(0,1,1,OP_J,   0,0,16'h0,26'h40, 32'h0040_0010,0,0);  // slot
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0,  32'h0000_0100,1,1);
        add(0,1,1,OP_BEQ, 5,5,16'h4,26'h0,  32'h0000_0104,0,1);  // pend 0x114
        add(0,1,1,OP_J,   0,0,16'h0,26'h3FF,32'h0000_0114,1,2);  // J in slot ignored
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0,  32'h0000_0118,0,2);
        add(0,1,1,OP_BEQ, 1,1,16'h2,26'h0,  32'h0000_011C,0,2);  // pend 0x124
        add(0,0,1,OP_J,   0,0,16'h0,26'h7,  32'h0000_011C,0,2);
        add(0,0,0,OP_NONE,0,0,16'h0,26'h0,  32'h0000_011C,0,2);
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0,  32'h0000_0124,1,3);
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0,  32'h0000_0128,0,3);
        add(0,1,1,OP_BNE, 3,3,16'h8,26'h0,  32'h0000_012C,0,3);
`else
        add(0,1,1,OP_J,   0,0,16'h0,26'h40,         32'h0000_0100,1,1);
        add(0,1,1,OP_BEQ, 5,5,16'h3,26'h0,          32'h0000_0110,1,2);
        add(0,1,1,OP_J,   0,0,16'h0,26'h40,         32'h0000_0100,1,3);
        add(0,1,1,OP_BEQ, 5,6,16'h3,26'h0,          32'h0000_0104,0,3);
        add(0,1,1,OP_J,   0,0,16'h0,26'h80,         32'h0000_0200,1,4);
        add(0,1,1,OP_BNE, 1,2,16'hFFFE,26'h0,       32'h0000_01FC,1,5);
        add(0,1,1,OP_BLEZ,32'h8000_0000,0,16'h1,26'h0, 32'h0000_0204,1,6);
        add(0,1,1,OP_BGTZ,0,0,16'h1,26'h0,          32'h0000_0208,0,6);
        add(0,1,1,3'd7,   0,0,16'h5,26'h0,          32'h0000_020C,0,6);
        add(0,1,1,3'd6,   0,0,16'h5,26'h0,          32'h0000_0210,0,6);
        add(0,1,1,OP_BLEZ,0,0,16'h0,26'h0,          32'h0000_0214,1,7);
        add(0,1,1,OP_BGTZ,1,0,16'h0,26'h0,          32'h0000_0218,1,8);
        add(0,1,1,OP_BLEZ,1,0,16'h0,26'h0,          32'h0000_021C,0,8);
        add(0,1,0,OP_J,   0,0,16'h0,26'h0,          32'h0000_0220,0,8);
        add(0,1,1,OP_J,   0,0,16'h0,26'h0,          32'h0000_0000,1,9);
        add(0,1,1,OP_BNE, 1,2,16'hFFFE,26'h0,       32'hFFFF_FFFC,1,10);
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0,          32'h0000_0000,0,10);
        add(0,1,1,OP_BNE, 1,2,16'hFFFE,26'h0,       32'hFFFF_FFFC,1,11);
        add(0,0,1,OP_BEQ, 1,1,16'h3,26'h0,          32'hFFFF_FFFC,0,11);
        add(0,0,1,OP_BEQ, 1,1,16'h3,26'h0,          32'hFFFF_FFFC,0,11);
        add(0,0,1,OP_BEQ, 1,1,16'h3,26'h0,          32'hFFFF_FFFC,0,11);
        add(0,1,1,OP_BEQ, 1,1,16'h3,26'h0,          32'h0000_000C,1,12);
        add(0,1,0,OP_NONE,0,0,16'h0,26'h0,          32'h0000_0010,0,12);
        // dut_b: J into the 0x9 region, then saturation of the 2-bit counter
        add(1,1,1,OP_J,   0,0,16'h0,26'h40, 32'h9000_0100,1,1);
        add(1,1,1,OP_BEQ, 0,0,16'h0,26'h0,  32'h9000_0104,1,2);
        add(1,1,1,OP_BEQ, 0,0,16'h0,26'h0,  32'h9000_0108,1,3);
        add(1,1,1,OP_BEQ, 0,0,16'h0,26'h0,  32'h9000_010C,1,3);
        add(1,1,1,OP_BEQ, 0,0,16'h0,26'h0,  32'h9000_0110,1,3);
        add(1,1,0,OP_NONE,0,0,16'h0,26'h0,  32'h9000_0114,0,3);
`endif

        drive(0,0,0,OP_NONE,0,0,0,0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_a("reset a", 32'h0040_0000, 1'b0, 16'd0);
        check("reset b pc", bus_b.pc, 32'h9000_0010);
        check("reset b taken_cnt", {30'd0, bus_b.taken_cnt}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].en, vecs[i].iv, vecs[i].op, vecs[i].rs,
                  vecs[i].rt, vecs[i].imm, vecs[i].jidx);
            @(posedge clk);
            #1;
            if (vecs[i].sel) begin
                act_pc = bus_b.pc; act_tk = bus_b.taken; act_cnt = {14'd0, bus_b.taken_cnt};
            end else begin
                act_pc = bus_a.pc; act_tk = bus_a.taken; act_cnt = bus_a.taken_cnt;
            end
            check($sformatf("vec%0d pc", i), act_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d taken", i), {31'd0, act_tk}, {31'd0, vecs[i].exp_taken});
            check($sformatf("vec%0d taken_cnt", i), {16'd0, act_cnt}, {16'd0, vecs[i].exp_cnt});
            $display("vec %0d dut%s: pc=%08h taken=%b cnt=%0d", i, vecs[i].sel ? "b" : "a",
                     act_pc, act_tk, act_cnt);
        end

        // Reset while a taken branch is being resolved (deferred under the delay-slot build)
        drive(0,1,1,OP_BEQ,1,1,16'h4,26'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_a("mid reset", 32'h0040_0000, 1'b0, 16'd0);
        rst = 1'b0;
        drive(0,1,0,OP_NONE,0,0,0,0);
        @(posedge clk);
        #1;
        check_a("post reset 1", 32'h0040_0004, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        check_a("post reset 2", 32'h0040_0008, 1'b0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Parametrised next-PC and branch-resolution unit for the single-issue MIPS-style core. It holds the architectural PC register and resolves the following control-flow operations directly from register operands: BEQ, BNE, BLEZ, BGTZ and J. It advances the PC every enabled cycle. It also keeps a saturating taken-branch counter for debug.

Parameters:
XLEN, 32, datapath and PC width; must be >= 32
RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0
CNT_W, 16, width of taken-branch counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, synchronous, active-high
en  input  1  advance enable; 0 = stall, all state holds
instr_valid  input  1  op/operands valid this cycle
op  input  3  0=NONE 1=BEQ 2=BNE 3=BLEZ 4=BGTZ 5=J; 6,7 treated as NONE
rs_val  input  XLEN  rs register operand
rt_val  input  XLEN  rt register operand
imm  input  16  branch offset, signed, in words
jidx  input  26  jump index field
pc  output  XLEN  current PC (registered)
pc_plus4  output  XLEN  pc+4, combinational from pc
taken  output  1  registered; 1 for exactly one cycle after a PC redirect
taken_cnt  output  CNT_W  count of redirects, saturating

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, taken=0, taken_cnt=0, FSM=NORMAL. Reset takes priority over en and all other inputs.
- Condition evaluation (combinational):
  - BEQ: rs_val==rt_val.
  - BNE: rs_val!=rt_val.
  - BLEZ: $signed(rs_val)<=0.
  - BGTZ: $signed(rs_val)>0.
  - J: always true.
  - NONE, 6, 7: false.
- Branch target = pc_plus4 + (sign_extend(imm) << 2), computed modulo 2^XLEN.
- Jump target = {pc_plus4[XLEN-1:28], jidx, 2'b00}.
- pc_plus4 wraps modulo 2^XLEN. pc[1:0] is always 00.
- en=0 (stall):
  - pc, FSM, pending target and taken_cnt hold.
  - taken <= 0.
- en=1, instr_valid=0: pc <= pc_plus4. op is ignored. taken <= 0.
- en=1, instr_valid=1, condition false: pc <= pc_plus4, taken <= 0.
- en=1, instr_valid=1, condition true, FSM NORMAL: redirect to target (immediate or deferred, see Optional Feature).
- On every redirect actually applied to pc:
  - taken <= 1 for one cycle.
  - taken_cnt <= taken_cnt+1, holding at all-ones (no wrap).
- Latency: pc is updated 1 cycle after the decision cycle. taken asserts in the same cycle pc shows the redirected value.
- FSM states:
  - NORMAL: only state when the macro is absent.
  - SLOT: delay slot pending, exists only with the macro.
  - NORMAL -> SLOT on a taken branch/jump (macro only).
  - SLOT -> NORMAL on the next en=1 cycle.
- Back-to-back taken branches in NORMAL (macro absent): each is resolved independently, one redirect per enabled cycle.
- Reset mid-SLOT: the pending target is discarded. pc=RESET_PC, FSM=NORMAL.

Optional Feature:
BRANCH_DELAY_SLOT_EN
- Defined:
  - A taken branch/jump in NORMAL latches its target into pend_pc and sets pc <= pc_plus4 (the delay slot). FSM -> SLOT. taken stays 0 that cycle.
  - On the next en=1 cycle in SLOT: pc <= pend_pc, taken <= 1, taken_cnt increments, FSM -> NORMAL.
  - Any branch/jump presented while in SLOT is ignored: treated as NONE, no count.
  - Stalls (en=0) in SLOT hold pend_pc.
- Undefined:
  - No SLOT state and no pend_pc register.
  - A taken branch/jump sets pc <= target in the same enabled edge.

Test Plan:
1. Reset with RESET_PC=0x00400000; hold rst 2 cycles, then en=1, instr_valid=0 for 3 cycles -> pc = 0x00400000, then 0x00400004, 0x00400008, 0x0040000C; taken=0; taken_cnt=0.
2. pc=0x100, BEQ, rs=rt=5, imm=0x0003 -> next pc=0x110, taken=1 for one cycle, taken_cnt=1. Repeat with BEQ, rs=5, rt=6 -> pc=0x104, taken=0.
3. pc=0x200:
   - BNE, imm=0xFFFE, rs!=rt -> pc=0x1FC (negative offset).
   - BLEZ, rs=0x80000000 -> taken.
   - BGTZ, rs=0 -> not taken.
   - op=7 -> pc+4.
4. pc=0x9000_0010, J, jidx=0x0000040 -> pc=0x9000_0100. Then pc=0xFFFF_FFFC with no branch -> pc=0x0000_0000 (wrap).
5. en=0 for 3 cycles with BEQ taken presented -> pc, taken_cnt unchanged, taken=0. Release en -> redirect occurs once. With CNT_W=2, 5 taken branches -> taken_cnt saturates at 3.
6. Macro defined: pc=0x100, BEQ taken, imm=0x0004 -> pc 0x104 (slot, taken=0). Next en cycle presents J in slot -> pc=0x114, taken=1, J ignored, taken_cnt=1. Separate run: rst asserted while in SLOT -> pc=RESET_PC, no later redirect.
